decode_stage_buffered: RTL

//  Parametrised RV32E/RV32I decode stage between fetch and execute. Decodes one instruction per cycle into
//  an OUT_DEPTH-entry output FIFO and reports register-use flags for hazard logic. Illegal encodings are

---
 rtl/decode_stage_buffered.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_buffered.sv
// decode_stage_buffered: RV32E/RV32I decode stage feeding an OUT_DEPTH-entry output FIFO.
// Ports:
//   clock, reset (async, active-high), flush (drop buffered work and clear error)
//   in_valid/in_ready/in_instruction/in_address   : fetch side handshake
//   out_valid/out_ready/out_*                      : FIFO head (kind, immediate, regs, use flags, address)
//   error_valid/cause/address/instruction, error_clear : illegal-encoding record
// Optional feature: define DECODE_M_EXT_EN to decode MUL..REMU on OP with funct7 = 0000001;
// without it that encoding is reported as a funct7 error.
// out_kind encoding is the order of instruction_kind_t below (INST_NOP = 0 ... INST_REMU = 45).
module decode_stage_buffered #(
    parameter int NUM_REGS  = 16,
    parameter int OUT_DEPTH = 2,
    parameter int ADDR_W    = 32,
    localparam int REG_W    = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instruction,
    input  logic [ADDR_W-1:0] in_address,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_kind,
    output logic [31:0]       out_immediate,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rs1,
    output logic [REG_W-1:0]  out_rs2,
    output logic              out_uses_rd,
    output logic              out_uses_rs1,
    output logic              out_uses_rs2,
    output logic [ADDR_W-1:0] out_address,
    output logic              error_valid,
    output logic [1:0]        error_cause,
    output logic [ADDR_W-1:0] error_address,
    output logic [31:0]       error_instruction,
    input  logic              error_clear
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    typedef enum logic [5:0] {
        INST_NOP, INST_LUI, INST_AUIPC, INST_JAL, INST_JALR,
        INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU,
        INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU,
        INST_SB, INST_SH, INST_SW,
        INST_ADDI, INST_SLTI, INST_SLTIU, INST_XORI, INST_ORI, INST_ANDI,
        INST_SLLI, INST_SRLI, INST_SRAI,
        INST_ADD, INST_SUB, INST_SLL, INST_SLT, INST_SLTU, INST_XOR,
        INST_SRL, INST_SRA, INST_OR, INST_AND,
        INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU,
        INST_DIV, INST_DIVU, INST_REM, INST_REMU
    } instruction_kind_t;

    typedef struct packed {
        logic [5:0]        kind;
        logic [31:0]       imm;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [2:0]        uses;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    logic [6:0]  w_opc, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    logic [5:0]  w_kind;
    logic [31:0] w_imm;
    logic [2:0]  w_uses;
    logic        w_bad_op, w_bad_f3, w_bad_f7, w_bad_reg, w_illegal;
    logic [1:0]  w_cause;
    logic        w_accept, w_push, w_pop;
    entry_t      w_entry, w_out;

    entry_t              r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err_valid;
    logic [1:0]          r_err_cause;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [31:0]         r_err_instr;

    assign w_opc    = in_instruction[6:0];
    assign w_f3     = in_instruction[14:12];
    assign w_f7     = in_instruction[31:25];
    assign w_rd     = in_instruction[11:7];
    assign w_rs1    = in_instruction[19:15];
    assign w_rs2    = in_instruction[24:20];
    assign w_imm_i  = {{20{in_instruction[31]}}, in_instruction[31:20]};
    assign w_imm_s  = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
    assign w_imm_b  = {{20{in_instruction[31]}}, in_instruction[7], in_instruction[30:25], in_instruction[11:8], 1'b0};
    assign w_imm_u  = {in_instruction[31:12], 12'b0};
    assign w_imm_j  = {{12{in_instruction[31]}}, in_instruction[19:12], in_instruction[20], in_instruction[30:21], 1'b0};
    assign w_imm_sh = {27'b0, in_instruction[24:20]};

    // w_uses bit order is {rd, rs1, rs2}
    always_comb begin
        w_kind   = INST_NOP;
        w_imm    = '0;
        w_uses   = 3'b000;
        w_bad_op = 1'b0;
        w_bad_f3 = 1'b0;
        w_bad_f7 = 1'b0;
        case (w_opc)
            7'b0110111: begin w_kind = INST_LUI;   w_imm = w_imm_u; w_uses = 3'b100; end
            7'b0010111: begin w_kind = INST_AUIPC; w_imm = w_imm_u; w_uses = 3'b100; end
            7'b1101111: begin w_kind = INST_JAL;   w_imm = w_imm_j; w_uses = 3'b100; end
            7'b1100111: begin
                w_kind   = INST_JALR;
                w_imm    = w_imm_i;
                w_uses   = 3'b110;
                w_bad_f3 = w_f3 != 3'b000;
            end
            7'b1100011: begin
                w_kind   = w_f3[2] ? INST_BLT + {4'b0, w_f3[1:0]} : INST_BEQ + {5'b0, w_f3[0]};
                w_imm    = w_imm_b;
                w_uses   = 3'b011;
                w_bad_f3 = w_f3[2:1] == 2'b01;
            end
            7'b0000011: begin
                w_kind   = w_f3[2] ? INST_LBU + {5'b0, w_f3[0]} : INST_LB + {4'b0, w_f3[1:0]};
                w_imm    = w_imm_i;
                w_uses   = 3'b110;
                w_bad_f3 = w_f3 == 3'b011 || w_f3[2:1] == 2'b11;
            end
            7'b0100011: begin
                w_kind   = INST_SB + {4'b0, w_f3[1:0]};
                w_imm    = w_imm_s;
                w_uses   = 3'b011;
                w_bad_f3 = w_f3[2] || w_f3[1:0] == 2'b11;
            end
            7'b0010011: begin
                w_uses = 3'b110;
                w_imm  = (w_f3[1:0] == 2'b01) ? w_imm_sh : w_imm_i;
                case (w_f3)
                    3'b000: w_kind = INST_ADDI;
                    3'b001: w_kind = INST_SLLI;
                    3'b010: w_kind = INST_SLTI;
                    3'b011: w_kind = INST_SLTIU;
                    3'b100: w_kind = INST_XORI;
                    3'b101: w_kind = w_f7[5] ? INST_SRAI : INST_SRLI;
                    3'b110: w_kind = INST_ORI;
                    default: w_kind = INST_ANDI;
                endcase
                // bit 30 selects SRAI; every other funct7 bit must be zero for shifts
                w_bad_f7 = (w_f3 == 3'b001 && w_f7 != 7'b0) ||
                           (w_f3 == 3'b101 && (w_f7 & 7'b1011111) != 7'b0);
            end
            7'b0110011: begin
                w_uses = 3'b111;
                if (w_f7 == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
                    w_kind = INST_MUL + {3'b0, w_f3};
`else
                    w_bad_f7 = 1'b1;
`endif
                end else begin
                    case (w_f3)
                        3'b000: w_kind = w_f7[5] ? INST_SUB : INST_ADD;
                        3'b001: w_kind = INST_SLL;
                        3'b010: w_kind = INST_SLT;
                        3'b011: w_kind = INST_SLTU;
                        3'b100: w_kind = INST_XOR;
                        3'b101: w_kind = w_f7[5] ? INST_SRA : INST_SRL;
                        3'b110: w_kind = INST_OR;
                        default: w_kind = INST_AND;
                    endcase
                    // only ADD/SUB and SRL/SRA have an alternate (bit 30) encoding
                    w_bad_f7 = (w_f3 == 3'b000 || w_f3 == 3'b101) ? (w_f7 & 7'b1011111) != 7'b0 : w_f7 != 7'b0;
                end
            end
            7'b0001111, 7'b1110011: w_imm = w_imm_i;
            default: w_bad_op = 1'b1;
        endcase
    end

    // only architecturally used fields are range-checked
    assign w_bad_reg = (w_uses[2] && 32'(w_rd)  >= NUM_REGS) ||
                       (w_uses[1] && 32'(w_rs1) >= NUM_REGS) ||
                       (w_uses[0] && 32'(w_rs2) >= NUM_REGS);
    assign w_illegal = w_bad_op || w_bad_f3 || w_bad_f7 || w_bad_reg;
    assign w_cause   = w_bad_op ? 2'd0 : w_bad_f3 ? 2'd1 : w_bad_f7 ? 2'd2 : 2'd3;

    assign w_entry.kind = w_kind;
    assign w_entry.imm  = w_imm;
    assign w_entry.rd   = w_uses[2] ? in_instruction[7 +: REG_W]  : '0;
    assign w_entry.rs1  = w_uses[1] ? in_instruction[15 +: REG_W] : '0;
    assign w_entry.rs2  = w_uses[0] ? in_instruction[20 +: REG_W] : '0;
    assign w_entry.uses = w_uses;
    assign w_entry.addr = in_address;

    // capacity is judged on registered count only, so a pop never frees space in the same cycle
    assign in_ready  = !reset && !r_err_valid && (32'(r_count) < OUT_DEPTH);
    assign out_valid = r_count != '0;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && !w_illegal;
    assign w_pop     = out_valid && out_ready;

    assign w_out         = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_kind      = w_out.kind;
    assign out_immediate = w_out.imm;
    assign out_rd        = w_out.rd;
    assign out_rs1       = w_out.rs1;
    assign out_rs2       = w_out.rs2;
    assign out_uses_rd   = w_out.uses[2];
    assign out_uses_rs1  = w_out.uses[1];
    assign out_uses_rs2  = w_out.uses[0];
    assign out_address   = w_out.addr;

    assign error_valid       = r_err_valid;
    assign error_cause       = r_err_cause;
    assign error_address     = r_err_addr;
    assign error_instruction = r_err_instr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_err_valid <= 1'b0;
            r_err_cause <= '0;
            r_err_addr  <= '0;
            r_err_instr <= '0;
        end else if (flush) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_err_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= (r_wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_accept && w_illegal) begin
                r_err_valid <= 1'b1;
                r_err_cause <= w_cause;
                r_err_addr  <= in_address;
                r_err_instr <= in_instruction;
            end else if (error_clear) begin
                r_err_valid <= 1'b0;
            end
        end
    end
endmodule
